led_display_ram_arbiter: RTL and testbench
==========================================

# led_display_ram_arbiter

Arbitrates the single-port display frame RAM between two requesters: the row-fetch reader and the frame writer (host or pattern loader). The reader is latency-critical because the panel scan must not stall, so it has priority. A bounded-streak rule guarantees the writer forward progress. The block sits between the requesters and the RAM primitive, owns the RAM address/write-enable pins, and returns read data with fixed latency.

## Interface
- ADDR_W, 13, RAM word address width
- DATA_W, 32, RAM word width
- RD_STREAK_MAX, 4, maximum consecutive read grants while a write is pending (legal range 1–15)

- clk_in  in  1  clock
- n_reset_in  in  1  reset; asynchronous assert, active-low
- rd_req_in  in  1  read request; held with address until granted
- rd_addr_in  in  ADDR_W  read address
- rd_grant_out  out  1  combinational; read accepted this cycle
- rd_data_out  out  DATA_W  read data, registered
- rd_data_valid_out  out  1  one-cycle strobe qualifying rd_data_out
- wr_req_in  in  1  write request; held with address/data until granted
- wr_addr_in  in  ADDR_W  write address
- wr_data_in  in  DATA_W  write data
- wr_grant_out  out  1  combinational; write accepted this cycle
- ram_addr_out  out  ADDR_W  RAM address, registered
- ram_wdata_out  out  DATA_W  RAM write data, registered
- ram_we_out  out  1  RAM write enable, registered
- ram_rdata_in  in  DATA_W  RAM read data; synchronous read, 1-cycle latency

## Operation
- At most one grant per cycle. A request is accepted when `req && grant` is high at a rising edge.
- FSM, 2 states:
  - RD_PRI (reset state): `rd_req_in` wins over `wr_req_in`.
  - WR_FORCE: `wr_req_in` wins over `rd_req_in`.
- Streak counter `rd_streak` (4 bits):
  - Increments on each read grant while `wr_req_in` is high.
  - Clears on any write grant, or in any cycle `wr_req_in` is low.
- Transitions:
  - RD_PRI → WR_FORCE when a read grant would make `rd_streak == RD_STREAK_MAX` and `wr_req_in` is high.
  - WR_FORCE → RD_PRI on the next write grant. Exactly one forced write is issued per streak.
  - If `wr_req_in` drops while in WR_FORCE, return to RD_PRI and clear `rd_streak`.
- Only one requester active: that requester is granted immediately, whatever the FSM state.
- Granted write: `ram_addr_out`, `ram_wdata_out` and `ram_we_out=1` are driven in the next cycle.
- Granted read: `ram_addr_out` is driven in the next cycle with `ram_we_out=0`, and a read tag enters a 2-stage valid pipeline.
- Idle cycle (no grant): `ram_we_out=0`, and `ram_addr_out` and `ram_wdata_out` hold their previous values.
- Ordering: a write granted in cycle k followed by a read of the same address granted in cycle k+1 returns the new data, because the RAM sees the write first.
- Address arithmetic: none. Addresses pass through unmodified, with full ADDR_W width and no wrap logic.

## Timing
- Reset values, all applied asynchronously:
  - `ram_addr_out=0`, `ram_wdata_out=0`, `ram_we_out=0`
  - `rd_data_out=0`, `rd_data_valid_out=0`
  - FSM=RD_PRI, `rd_streak=0`, read pipeline tags cleared
- Grants are combinational from `rd_req_in`, `wr_req_in` and the FSM state. There is no combinational path from the address or data inputs to the grants.
- Read latency, counted from grant cycle k:
  - RAM address in cycle k+1
  - `ram_rdata_in` valid in cycle k+2
  - `rd_data_out` and `rd_data_valid_out=1` in cycle k+3
- Read throughput is one per cycle. Back-to-back grants yield back-to-back valid strobes.
- Write latency is 1 cycle: grant in cycle k, `ram_we_out` high in cycle k+1 only.
- A forced write inserts exactly one bubble into the read stream. The reader sees `rd_grant_out=0` for that one cycle.
- Reset asserted mid-operation: in-flight read tags are discarded and no valid strobe is emitted after reset releases. Requests must be re-presented.
- Reset deassertion is synchronized externally. The first grant is possible in the first cycle after release.

## Test plan
- Single read, addr 0x005, RAM word 0xDEADBEEF → `rd_grant_out` high in cycle 0; `ram_addr_out=0x005` in cycle 1; `rd_data_out=0xDEADBEEF` with valid in cycle 3.
- Write 0x1234_5678 to 0x0A0, then read 0x0A0 in the next cycle → `ram_we_out` high in cycle 1 only; read returns 0x12345678 in cycle 4.
- `rd_req_in` and `wr_req_in` held high continuously, RD_STREAK_MAX=4 → grant pattern R,R,R,R,W repeating; `rd_streak` never exceeds 4.
- `wr_req_in` pulsed for 2 cycles during continuous reads → no write granted, `rd_streak` returns to 0, FSM stays RD_PRI.
- Write only, 8 requests back-to-back to 0x000–0x007 → 8 consecutive `wr_grant_out` and 8 consecutive `ram_we_out` cycles with incrementing addresses.
- Reset asserted 1 cycle after a read grant → all outputs go to reset values immediately; no `rd_data_valid_out` after release.

Source files
------------

// File: rtl/led_display_ram_arbiter.sv
// Display frame RAM arbiter: the row-fetch reader has priority over the frame
// writer, and a bounded read streak forces one write through so the writer
// always makes progress. Owns the RAM pins and returns read data at a fixed
// three-cycle latency from grant.
module led_display_ram_arbiter #(
    parameter int ADDR_W        = 13,
    parameter int DATA_W        = 32,
    parameter int RD_STREAK_MAX = 4
) (
    input  logic              clk_in,
    input  logic              n_reset_in,
    input  logic              rd_req_in,
    input  logic [ADDR_W-1:0] rd_addr_in,
    output logic              rd_grant_out,
    output logic [DATA_W-1:0] rd_data_out,
    output logic              rd_data_valid_out,
    input  logic              wr_req_in,
    input  logic [ADDR_W-1:0] wr_addr_in,
    input  logic [DATA_W-1:0] wr_data_in,
    output logic              wr_grant_out,
    output logic [ADDR_W-1:0] ram_addr_out,
    output logic [DATA_W-1:0] ram_wdata_out,
    output logic              ram_we_out,
    input  logic [DATA_W-1:0] ram_rdata_in
);

    localparam logic [3:0] STREAK_MAX = 4'(RD_STREAK_MAX);

    typedef enum logic {
        RD_PRI   = 1'b0,
        WR_FORCE = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        streak_q, streak_d;
    logic [3:0]        streak_inc;
    logic              rd_grant, wr_grant;

    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic              ram_we_q;
    logic [1:0]        vld_pipe_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    // Grants depend only on the requests and the FSM state, never on addr/data.
    always_comb begin
        rd_grant = 1'b0;
        wr_grant = 1'b0;
        if (rd_req_in && wr_req_in) begin
            if (state_q == WR_FORCE) wr_grant = 1'b1;
            else                     rd_grant = 1'b1;
        end else begin
            rd_grant = rd_req_in;
            wr_grant = wr_req_in;
        end
    end

    // Streak bookkeeping and priority flip; the streak only counts reads that
    // actually held a pending write off.
    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        streak_inc = streak_q + 4'd1;
        if (!wr_req_in || wr_grant) begin
            streak_d = 4'd0;
            state_d  = RD_PRI;
        end else if (rd_grant) begin
            streak_d = streak_inc;
            if (streak_inc == STREAK_MAX) state_d = WR_FORCE;
        end
    end

    // FSM state and streak counter.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state_q  <= RD_PRI;
            streak_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    // RAM pin registers; address and write data hold across idle cycles.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
        end else begin
            ram_we_q <= wr_grant;
            if (wr_grant) begin
                ram_addr_q  <= wr_addr_in;
                ram_wdata_q <= wr_data_in;
            end else if (rd_grant) begin
                ram_addr_q  <= rd_addr_in;
            end
        end
    end

    // Read tag pipeline: stage 0 = address on RAM, stage 1 = RAM data valid,
    // then the output register captures it.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            vld_pipe_q <= 2'b00;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[0], rd_grant};
            rd_valid_q <= vld_pipe_q[1];
            if (vld_pipe_q[1]) rd_data_q <= ram_rdata_in;
        end
    end

    assign rd_grant_out      = rd_grant;
    assign wr_grant_out      = wr_grant;
    assign ram_addr_out      = ram_addr_q;
    assign ram_wdata_out     = ram_wdata_q;
    assign ram_we_out        = ram_we_q;
    assign rd_data_out       = rd_data_q;
    assign rd_data_valid_out = rd_valid_q;

endmodule

// File: tb/tb_led_display_ram_arbiter.sv
// Bench for led_display_ram_arbiter: a behavioural RAM, a transaction-level
// reference model, a grant-pattern vector table, hand sequences for latency,
// ordering, bursts and reset, and randomized request traffic.
module tb_led_display_ram_arbiter;
    localparam int AW  = 13;
    localparam int DW  = 32;
    localparam int MAX = 4;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          rd_req, wr_req;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_grant, wr_grant, rd_valid, ram_we;
    logic [DW-1:0] rd_data, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;

    always #5 clk = ~clk;

    led_display_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_STREAK_MAX(MAX)) dut (
        .clk_in(clk), .n_reset_in(n_reset),
        .rd_req_in(rd_req), .rd_addr_in(rd_addr), .rd_grant_out(rd_grant),
        .rd_data_out(rd_data), .rd_data_valid_out(rd_valid),
        .wr_req_in(wr_req), .wr_addr_in(wr_addr), .wr_data_in(wr_data),
        .wr_grant_out(wr_grant), .ram_addr_out(ram_addr), .ram_wdata_out(ram_wdata),
        .ram_we_out(ram_we), .ram_rdata_in(ram_rdata)
    );

    // Single-port synchronous RAM, one-cycle read latency.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    int checks = 0;
    int errors = 0;

    // Reference model state (transaction level).
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            streak;
    bit            owe_write;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rlast;
    bit            g1, g2, g3;
    logic [DW-1:0] d1, d2, d3;

    // Values seen at the most recent sample point.
    bit            obs_we, obs_valid;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_data;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        streak = 0; owe_write = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_rlast = '0;
        g1 = 0; g2 = 0; g3 = 0; d1 = '0; d2 = '0; d3 = '0;
    endtask

    // One clock cycle: drive, sample at negedge, compare against model, advance.
    task automatic cycle(input bit rq, input logic [AW-1:0] ra, input bit wq,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         output bit og_r, output bit og_w);
        bit pr, pw;
        rd_req = rq; rd_addr = ra; wr_req = wq; wr_addr = wa; wr_data = wd;
        @(negedge clk);
        obs_we = ram_we; obs_addr = ram_addr; obs_valid = rd_valid; obs_data = rd_data;
        chk("ram_we", ram_we, m_we);
        chk("ram_addr", ram_addr, m_addr);
        chk("ram_wdata", ram_wdata, m_wdata);
        chk("rd_valid", rd_valid, g3);
        if (g3) m_rlast = d3;
        chk("rd_data", rd_data, m_rlast);
        // Reader wins unless a forced write is owed; a lone requester always wins.
        pr = rq && (!wq || !owe_write);
        pw = wq && (!rq || owe_write);
        chk("rd_grant", rd_grant, pr);
        chk("wr_grant", wr_grant, pw);
        og_r = rd_grant; og_w = wr_grant;
        if (!wq || pw) begin
            streak = 0; owe_write = 0;
        end else if (pr) begin
            streak++;
            if (streak == MAX) owe_write = 1;
        end
        m_we = pw;
        if (pw) begin
            m_addr = wa; m_wdata = wd; ref_mem[wa] = wd;
        end else if (pr) begin
            m_addr = ra;
        end
        g3 = g2; d3 = d2; g2 = g1; d2 = d1; g1 = pr; d1 = ref_mem[ra];
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bit a, b;
        for (int i = 0; i < n; i++) cycle(0, '0, 0, '0, '0, a, b);
    endtask

    typedef struct {
        bit rd; bit wr; bit erg; bit ewg;
    } vec_t;
    vec_t tbl [26];

    initial begin
        bit gr, gw, rp, wp;
        logic [AW-1:0] ra, wa;
        logic [DW-1:0] wd;
        int wn, k;

        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]     = i * 32'h9E3779B1 ^ 32'h5A5A0000;
            ref_mem[i] = i * 32'h9E3779B1 ^ 32'h5A5A0000;
        end
        ram[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;

        // Grant-pattern table: R,R,R,R,W under continuous contention; a short
        // write pulse that never gets through and clears the streak; lone writes.
        k = 0;
        for (int i = 0; i < 10; i++) begin tbl[k] = '{1, 1, (i % 5) != 4, (i % 5) == 4}; k++; end
        for (int i = 0; i < 2; i++)  begin tbl[k] = '{1, 1, 1, 0}; k++; end
        for (int i = 0; i < 3; i++)  begin tbl[k] = '{1, 0, 1, 0}; k++; end
        for (int i = 0; i < 5; i++)  begin tbl[k] = '{1, 1, i != 4, i == 4}; k++; end
        for (int i = 0; i < 2; i++)  begin tbl[k] = '{0, 1, 0, 1}; k++; end
        for (int i = 0; i < 2; i++)  begin tbl[k] = '{1, 0, 1, 0}; k++; end
        for (int i = 0; i < 2; i++)  begin tbl[k] = '{0, 0, 0, 0}; k++; end

        rd_req = 0; wr_req = 0; rd_addr = '0; wr_addr = '0; wr_data = '0;
        n_reset = 0;
        model_reset();
        #12;
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        @(posedge clk); #1;
        n_reset = 1;

        // Table vectors, starting in the first cycle after reset release.
        wn = 0;
        for (int i = 0; i < 26; i++) begin
            cycle(tbl[i].rd, AW'(13'h100 + i), tbl[i].wr, AW'(13'h200 + wn),
                  32'hC0DE0000 + wn, gr, gw);
            chk("tbl_rd_grant", gr, tbl[i].erg);
            chk("tbl_wr_grant", gw, tbl[i].ewg);
            if (gw) wn++;
        end
        idle(4);

        // Single read latency: addr in cycle 1, data in cycle 3.
        cycle(1, 13'h005, 0, '0, '0, gr, gw);
        chk("sr_grant_c0", gr, 1);
        cycle(0, '0, 0, '0, '0, gr, gw);
        chk("sr_addr_c1", obs_addr, 13'h005);
        cycle(0, '0, 0, '0, '0, gr, gw);
        chk("sr_valid_c2", obs_valid, 0);
        cycle(0, '0, 0, '0, '0, gr, gw);
        chk("sr_valid_c3", obs_valid, 1);
        chk("sr_data_c3", obs_data, 32'hDEADBEEF);
        idle(2);

        // Write then read of the same address in the next cycle.
        cycle(0, '0, 1, 13'h0A0, 32'h12345678, gr, gw);
        cycle(1, 13'h0A0, 0, '0, '0, gr, gw);
        chk("wr_we_c1", obs_we, 1);
        cycle(0, '0, 0, '0, '0, gr, gw);
        chk("wr_we_c2", obs_we, 0);
        cycle(0, '0, 0, '0, '0, gr, gw);
        cycle(0, '0, 0, '0, '0, gr, gw);
        chk("raw_valid_c4", obs_valid, 1);
        chk("raw_data_c4", obs_data, 32'h12345678);
        idle(2);

        // Back-to-back write burst to 0x000..0x007.
        for (int i = 0; i < 9; i++) begin
            cycle(0, '0, i < 8, AW'(i), 32'hA5000000 + i, gr, gw);
            if (i < 8) chk("burst_grant", gw, 1);
            if (i > 0) begin
                chk("burst_we", obs_we, 1);
                chk("burst_addr", obs_addr, AW'(i - 1));
            end
        end
        cycle(0, '0, 0, '0, '0, gr, gw);
        chk("burst_we_end", obs_we, 0);
        idle(2);

        // Reset one cycle after a read grant: in-flight tag must vanish.
        cycle(1, 13'h010, 0, '0, '0, gr, gw);
        n_reset = 0;
        #1;
        chk("mr_ram_addr", ram_addr, 0);
        chk("mr_ram_wdata", ram_wdata, 0);
        chk("mr_ram_we", ram_we, 0);
        chk("mr_rd_data", rd_data, 0);
        chk("mr_rd_valid", rd_valid, 0);
        @(posedge clk); #1;
        n_reset = 1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(0, '0, 0, '0, '0, gr, gw);
            chk("mr_no_valid", obs_valid, 0);
        end

        // Randomized traffic; requests held with their address/data until granted.
        rp = 0; wp = 0; ra = '0; wa = '0; wd = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!rp) begin
                rp = ($urandom_range(0, 99) < 70);
                ra = AW'($urandom_range(0, 63));
            end
            if (!wp) begin
                wp = ($urandom_range(0, 99) < 45);
                wa = AW'($urandom_range(0, 63));
                wd = $urandom;
            end
            cycle(rp, ra, wp, wa, wd, gr, gw);
            if (gr) rp = 0;
            if (gw) wp = 0;
        end
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
